// File: rtl/bp_pkg.sv
// Shared definitions for the two-level branch predictor.
//   MODE_LOCAL / MODE_GSHARE : values of the predictor MODE parameter
//   sat_upd()                : saturating up/down step of a CTR_W-bit counter
//   hist_shift()             : shift one outcome into a width-bit history
// Both helpers work on int so callers of any width can size-cast the
// result back down without leaving unused slices behind.
package bp_pkg;

  localparam int MODE_LOCAL  = 0;
  localparam int MODE_GSHARE = 1;

  // Move a counter one step toward taken/not-taken, clamping at both ends.
  function automatic int sat_upd(input int ctr, input logic taken, input int ctr_w);
    int ctr_max;
    ctr_max = (1 << ctr_w) - 1;
    if (taken) return (ctr < ctr_max) ? ctr + 1 : ctr;
    else       return (ctr > 0)       ? ctr - 1 : ctr;
  endfunction

  // Newest outcome enters at bit 0; bits above 'width' (the oldest) fall off.
  // With width = 1 the result is simply the new outcome.
  function automatic int hist_shift(input int hist, input logic bit_in, input int width);
    int mask;
    mask = (width >= 32) ? -1 : (1 << width) - 1;
    return ((hist << 1) | int'(bit_in)) & mask;
  endfunction

endpackage

// File: rtl/bp_sat_ctr_table.sv
// Pattern history table: 2**AW saturating counters held in flops.
//   clk, rst_n   : clock, asynchronous active-low reset (all entries -> CTR_INIT)
//   i_rd_idx     : combinational read index
//   o_rd_taken   : MSB of the addressed counter (the taken/not-taken verdict)
//   i_wr_en      : apply one saturating step at i_wr_idx this edge
//   i_wr_idx     : entry to update
//   i_wr_taken   : step direction (1 = increment, 0 = decrement)
module bp_sat_ctr_table
  import bp_pkg::*;
#(
  parameter int AW       = 5,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_rd_idx,
  output logic          o_rd_taken,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_idx,
  input  logic          i_wr_taken
);

  logic [CTR_W-1:0] r_ctr [2**AW];

  // Read sees the stored value only, so a same-cycle write to the same entry
  // becomes visible on the following cycle.
  assign o_rd_taken = r_ctr[i_rd_idx][CTR_W-1];

  // NOTE: every entry must start at a known counter value, so the array is
  // built from resettable flops; a RAM macro cannot be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) r_ctr[i] <= CTR_W'(CTR_INIT);
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= CTR_W'(sat_upd(int'(r_ctr[i_wr_idx]), i_wr_taken, CTR_W));
    end
  end

endmodule

// File: rtl/dyn_brnch_pred_2lvl_param.sv
// Two-level dynamic branch predictor between IF and ID.
//   clk, rst_n            : clock, asynchronous active-low reset
//   brch_addr_IF          : low PC bits of the IF instruction
//   brch_instr_detectd_IF : IF holds a branch
//   brch_addr_ID          : low PC bits of the ID branch
//   brch_instr_detectd_ID : ID holds a resolving branch
//   brch_hazard_stall     : IF/ID frozen this cycle (no update, pipeline holds)
//   actual_brch_result    : resolved direction in ID (1 = taken)
//   predict_br_taken      : zero-latency prediction for the IF instruction
//   brch_mispredict       : ID branch resolved against its prediction
//   mispred_cnt           : saturating count of mispredictions
// MODE selects the PHT index: local history per PC (LHT) or GHR ^ PC.
module dyn_brnch_pred_2lvl_param
  import bp_pkg::*;
#(
  parameter int IDX_W    = 5,
  parameter int HIST_W   = 5,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1,
  parameter int MODE     = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] brch_addr_IF,
  input  logic             brch_instr_detectd_IF,
  input  logic [IDX_W-1:0] brch_addr_ID,
  input  logic             brch_instr_detectd_ID,
  input  logic             brch_hazard_stall,
  input  logic             actual_brch_result,
  output logic             predict_br_taken,
  output logic             brch_mispredict,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic [HIST_W-1:0] w_pht_idx_if;
  logic              w_pred_if;
  logic              w_upd;
  logic [HIST_W-1:0] r_pht_idx_id;
  logic              r_pred_id;
  logic [CNT_W-1:0]  r_mispred_cnt;

  assign w_upd = brch_instr_detectd_ID & ~brch_hazard_stall;

  // ---------------------------------------------------------------------------
  // History source and PHT index
  // ---------------------------------------------------------------------------
  generate
    if (MODE == MODE_GSHARE) begin : g_gshare
      logic [HIST_W-1:0] r_ghr;
      logic [HIST_W-1:0] w_addr_ext;

      if (IDX_W >= HIST_W) begin : g_addr_trunc
        assign w_addr_ext = brch_addr_IF[HIST_W-1:0];
      end else begin : g_addr_zext
        assign w_addr_ext = {{(HIST_W-IDX_W){1'b0}}, brch_addr_IF};
      end

      assign w_pht_idx_if = r_ghr ^ w_addr_ext;

      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, which is what gives the "no bypass"
      // read-before-write behaviour.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_ghr <= '0;
        else if (w_upd) r_ghr <= HIST_W'(hist_shift(int'(r_ghr), actual_brch_result, HIST_W));
      end
    end else begin : g_local
      logic [HIST_W-1:0] r_lht [2**IDX_W];

      assign w_pht_idx_if = r_lht[brch_addr_IF];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 2**IDX_W; i++) r_lht[i] <= '0;
        end else if (w_upd) begin
          r_lht[brch_addr_ID] <=
            HIST_W'(hist_shift(int'(r_lht[brch_addr_ID]), actual_brch_result, HIST_W));
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pattern history table: read by IF, updated at the index IF used
  // ---------------------------------------------------------------------------
  bp_sat_ctr_table #(
    .AW       (HIST_W),
    .CTR_W    (CTR_W),
    .CTR_INIT (CTR_INIT)
  ) u_pht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_pht_idx_if),
    .o_rd_taken (w_pred_if),
    .i_wr_en    (w_upd),
    .i_wr_idx   (r_pht_idx_id),
    .i_wr_taken (actual_brch_result)
  );

  assign predict_br_taken = w_pred_if & brch_instr_detectd_IF;

  // ---------------------------------------------------------------------------
  // IF->ID carry of index and prediction; frozen together with IF/ID
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pht_idx_id <= '0;
      r_pred_id    <= 1'b0;
    end else if (!brch_hazard_stall) begin
      r_pht_idx_id <= w_pht_idx_if;
      r_pred_id    <= predict_br_taken;
    end
  end

  // ---------------------------------------------------------------------------
  // Misprediction flag and saturating counter
  // ---------------------------------------------------------------------------
  assign brch_mispredict = w_upd & (r_pred_id != actual_brch_result);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mispred_cnt <= '0;
    else if (brch_mispredict && (r_mispred_cnt != {CNT_W{1'b1}}))
      r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
  end

  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_dyn_brnch_pred_2lvl_param.sv
// Directed bench for dyn_brnch_pred_2lvl_param.
//   u_dut_loc : MODE=0 local predictor, default widths
//   u_dut_gsh : MODE=1 gshare, HIST_W=2, CNT_W=2 (counter saturation visible)
// Inputs change 1 time unit after a rising edge; outputs are sampled a
// further unit later, well away from the next edge.
module tb_dyn_brnch_pred_2lvl_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // local-mode instance
  logic [4:0]  a_addr_if, a_addr_id;
  logic        a_det_if, a_det_id, a_stall, a_act;
  logic        a_pred, a_mis;
  logic [15:0] a_cnt;

  // gshare instance
  logic [4:0]  b_addr_if, b_addr_id;
  logic        b_det_if, b_det_id, b_stall, b_act;
  logic        b_pred, b_mis;
  logic [1:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  dyn_brnch_pred_2lvl_param #(
    .IDX_W(5), .HIST_W(5), .CTR_W(2), .CTR_INIT(1), .MODE(0), .CNT_W(16)
  ) u_dut_loc (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .brch_addr_IF          (a_addr_if),
    .brch_instr_detectd_IF (a_det_if),
    .brch_addr_ID          (a_addr_id),
    .brch_instr_detectd_ID (a_det_id),
    .brch_hazard_stall     (a_stall),
    .actual_brch_result    (a_act),
    .predict_br_taken      (a_pred),
    .brch_mispredict       (a_mis),
    .mispred_cnt           (a_cnt)
  );

  dyn_brnch_pred_2lvl_param #(
    .IDX_W(5), .HIST_W(2), .CTR_W(2), .CTR_INIT(1), .MODE(1), .CNT_W(2)
  ) u_dut_gsh (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .brch_addr_IF          (b_addr_if),
    .brch_instr_detectd_IF (b_det_if),
    .brch_addr_ID          (b_addr_id),
    .brch_instr_detectd_ID (b_det_id),
    .brch_hazard_stall     (b_stall),
    .actual_brch_result    (b_act),
    .predict_br_taken      (b_pred),
    .brch_mispredict       (b_mis),
    .mispred_cnt           (b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic det_if, input logic [4:0] addr_if, input logic det_id,
                       input logic [4:0] addr_id, input logic stall, input logic act);
    a_det_if = det_if; a_addr_if = addr_if; a_det_id = det_id;
    a_addr_id = addr_id; a_stall = stall; a_act = act;
    #1;
  endtask

  task automatic drv_b(input logic det_if, input logic [4:0] addr_if, input logic det_id,
                       input logic [4:0] addr_id, input logic stall, input logic act);
    b_det_if = det_if; b_addr_if = addr_if; b_det_id = det_id;
    b_addr_id = addr_id; b_stall = stall; b_act = act;
    #1;
  endtask

  // Saturation run on PHT[0] (IF addr 7 keeps LHT index 0, ID addr 9 absorbs history)
  // columns: det_id, act, expected pred, expected mispredict
  logic [7:0] sat_det_id = 8'b0111_1110;
  logic [7:0] sat_act    = 8'b0011_1110;
  logic [7:0] sat_pred   = 8'b1111_1100;
  logic [7:0] sat_mis    = 8'b0100_0110;

  // gshare alternating T/N at addr 5, steps 0..9 (bit k = step k)
  logic [9:0] gs_pred = 10'b01_0101_0000;
  logic [9:0] gs_mis  = 10'b00_0000_1010;

  initial begin
    rst_n = 1'b0;
    drv_a(0, 0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0, 0);
    #10;
    check("rst_held_cnt_loc", a_cnt, 0);
    check("rst_held_cnt_gsh", b_cnt, 0);
    rst_n = 1'b1;
    tick();

    // ---- reset state: counters at weakly-not-taken everywhere ----
    for (int i = 0; i < 4; i++) begin
      logic [4:0] addr;
      addr = 5'(i * 10 + 1);
      drv_a(1, addr, 0, 0, 0, 0);
      drv_b(1, addr, 0, 0, 0, 0);
      check($sformatf("rst_pred_loc[%0d]", addr), a_pred, 0);
      check($sformatf("rst_pred_gsh[%0d]", addr), b_pred, 0);
    end
    check("rst_mis_loc", a_mis, 0);
    check("rst_mis_gsh", b_mis, 0);
    check("rst_cnt_loc", a_cnt, 0);
    tick();

    // ---- saturation + same-cycle read/update of PHT[0] ----
    // counter after each update: 2,3,3,3,3,2
    for (int s = 0; s < 8; s++) begin
      drv_a(1, 7, sat_det_id[s], 9, 0, sat_act[s]);
      check($sformatf("sat_pred[%0d]", s), a_pred, sat_pred[s]);
      check($sformatf("sat_mis[%0d]", s), a_mis, sat_mis[s]);
      tick();
    end
    check("sat_cnt", a_cnt, 3);

    // ---- stall: ID update pending for 3 cycles, nothing may move ----
    for (int s = 0; s < 3; s++) begin
      drv_a(0, 9, 1, 9, 1, 0);
      check($sformatf("stall_mis[%0d]", s), a_mis, 0);
      check($sformatf("stall_cnt[%0d]", s), a_cnt, 3);
      tick();
    end
    // held pred_id=1 vs not-taken -> one mispredict, PHT[0] 2->1
    drv_a(0, 9, 1, 9, 0, 0);
    check("unstall_mis", a_mis, 1);
    tick();
    drv_a(1, 7, 0, 0, 0, 0);
    check("unstall_pred", a_pred, 0);
    check("unstall_cnt", a_cnt, 4);
    tick();
    // one taken step must bring PHT[0] from 1 to 2 (proves a single decrement)
    drv_a(1, 7, 1, 10, 0, 1);
    check("retrain_mis", a_mis, 1);
    tick();
    drv_a(1, 7, 0, 0, 0, 0);
    check("retrain_pred", a_pred, 1);
    check("retrain_cnt", a_cnt, 5);
    tick();

    // ---- async reset mid-update ----
    drv_a(1, 7, 1, 11, 0, 1);
    check("pre_rst_pred", a_pred, 1);
    check("pre_rst_mis", a_mis, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", a_cnt, 0);
    check("async_rst_pred", a_pred, 0);
    tick();
    check("rst_edge_pred", a_pred, 0);
    rst_n = 1'b1;
    drv_a(1, 7, 0, 0, 0, 0);
    check("post_rst_pred", a_pred, 0);
    check("post_rst_mis", a_mis, 0);
    check("post_rst_cnt", a_cnt, 0);
    tick();

    // ---- local history: branch at addr 3 taken twice ----
    drv_a(1, 3, 0, 0, 0, 0);
    check("loc_c1_pred", a_pred, 0);
    tick();
    drv_a(1, 3, 1, 3, 0, 1);
    check("loc_c2_pred", a_pred, 0);
    check("loc_c2_mis", a_mis, 1);
    tick();
    drv_a(1, 3, 1, 3, 0, 1);
    check("loc_c3_pred", a_pred, 0);
    check("loc_c3_mis", a_mis, 1);
    tick();
    // PHT[0] now strongly taken; LHT[3]=00011 points at untouched PHT[3]
    drv_a(1, 7, 0, 0, 0, 0);
    check("loc_idx0_pred", a_pred, 1);
    check("loc_cnt", a_cnt, 2);
    tick();
    drv_a(1, 3, 0, 0, 0, 0);
    check("loc_idx3_pred", a_pred, 0);
    drv_a(0, 7, 0, 0, 0, 0);
    check("loc_no_det_pred", a_pred, 0);
    tick();

    // ---- gshare, alternating T/N at addr 5, one branch per cycle ----
    for (int k = 0; k < 10; k++) begin
      drv_b(1, 5, (k > 0), 5, 0, ((k - 1) % 2 == 0));
      check($sformatf("gs_pred[%0d]", k), b_pred, gs_pred[k]);
      check($sformatf("gs_mis[%0d]", k), b_mis, gs_mis[k]);
      tick();
    end
    // two forced mispredicts: counter 2 -> 3, then holds at 3
    drv_b(0, 0, 1, 5, 0, 1);
    check("gs_cnt_warm", b_cnt, 2);
    check("gs_force_mis0", b_mis, 1);
    tick();
    drv_b(0, 0, 1, 5, 0, 1);
    check("gs_force_mis1", b_mis, 1);
    check("gs_cnt_3", b_cnt, 3);
    tick();
    drv_b(0, 0, 0, 0, 0, 0);
    check("gs_cnt_sat", b_cnt, 3);
    check("gs_idle_mis", b_mis, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
